// File: rtl/rv32i_regfile_pkg.sv
// Shared constants and types for the multi-port RV32I register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  // Debug access FSM: IDLE accepts a request, ACK emits the one-cycle completion.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/rv32i_regfile_mp_if.sv
// Bundles the core write/read, scoreboard and debug signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: debug side uses req/ack; core side has none.
interface rv32i_regfile_mp_if
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF
) ();

  localparam int AW = $clog2(NREG);

  // Core write port
  logic              wen;
  logic [AW-1:0]     rd;
  logic [XLEN-1:0]   din;

  // Core read ports, port i packed at [i*AW +: AW] / [i*XLEN +: XLEN]
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;

  // Pending-write scoreboard set
  logic              sb_set;
  logic [AW-1:0]     sb_rd;

  // Debug access
  logic              dbg_req;
  logic              dbg_we;
  logic [AW-1:0]     dbg_addr;
  logic [XLEN-1:0]   dbg_wdata;
  logic              dbg_ack;
  logic [XLEN-1:0]   dbg_rdata;

  modport master (
    output wen, rd, din, rs_addr, sb_set, sb_rd,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  rs_data, rs_busy, dbg_ack, dbg_rdata
  );

  modport slave (
    input  wen, rd, din, rs_addr, sb_set, sb_rd,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output rs_data, rs_busy, dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/rv32i_regfile_rdport.sv
// One combinational read port: register mux, x0 forced to zero, write bypass, busy masking.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; busy flag tells the consumer the value is not yet final.
module rv32i_regfile_rdport
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           sb,
  input  logic                      wen,
  input  logic [AW-1:0]             rd,
  input  logic [XLEN-1:0]           din,
  input  logic [AW-1:0]             addr,
  output logic [XLEN-1:0]           data,
  output logic                      busy
);

  logic byp_hit;
  logic wr_match;

  // Forwarding applies only to real registers; a write to x0 is never visible.
  assign wr_match = wen && (rd == addr);
  assign byp_hit  = (BYPASS != 0) && wr_match && (rd != '0);

  // Select forwarded data, zero for x0, otherwise stored value.
  always_comb begin
    data = regs[addr];
    busy = sb[addr];
    if (addr == '0) begin
      data = '0;
    end
    if (byp_hit) begin
      data = din;
    end
    // The write that resolves the pending load lands this cycle, so the
    // consumer can take the forwarded value instead of stalling.
    if ((BYPASS != 0) && wr_match) begin
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// Flip-flop register file with NRD read ports, pending-load scoreboard and a debug access port.
// Latency: reads 0 cycles; core write 1 edge; debug access acks the cycle after acceptance.
// Backpressure: debug writes wait for a cycle without a core write; requester holds dbg_req until dbg_ack.
module rv32i_regfile_mp
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32i_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           sb_q;
  logic [NREG-1:0]           sb_d;
  dbg_state_e                state_q;
  dbg_state_e                state_d;
  logic                      dbg_acc;
  logic                      dbg_wr_acc;
  logic                      dbg_rd_acc;
  logic [XLEN-1:0]           dbg_rdata_q;
  logic [NRD-1:0][XLEN-1:0]  rp_data;
  logic [NRD-1:0]            rp_busy;

  // Debug FSM next state: reads go immediately, writes yield to a core write.
  always_comb begin
    state_d    = state_q;
    dbg_acc    = 1'b0;
    dbg_wr_acc = 1'b0;
    dbg_rd_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dbg_req && (!bus.dbg_we || !bus.wen)) begin
          dbg_acc    = 1'b1;
          dbg_wr_acc = bus.dbg_we;
          dbg_rd_acc = !bus.dbg_we;
          state_d    = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Debug FSM state register; reset mid-access drops the pending ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Register storage; x0 is never written so it stays zero from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      if (bus.wen && (bus.rd != '0)) begin
        regs_q[bus.rd] <= bus.din;
      end else if (dbg_wr_acc && (bus.dbg_addr != '0)) begin
        regs_q[bus.dbg_addr] <= bus.dbg_wdata;
      end
    end
  end

  // Scoreboard update: writes clear, a same-cycle set wins, bit 0 pinned low.
  always_comb begin
    sb_d = sb_q;
    if (bus.wen) begin
      sb_d[bus.rd] = 1'b0;
    end
    if (dbg_wr_acc) begin
      sb_d[bus.dbg_addr] = 1'b0;
    end
    if (bus.sb_set) begin
      sb_d[bus.sb_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Debug read capture uses the stored (pre-edge) value, never the bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata_q <= '0;
    end else if (dbg_rd_acc) begin
      dbg_rdata_q <= regs_q[bus.dbg_addr];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rdport
    rv32i_regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .BYPASS (BYPASS)
    ) u_rdport (
      .regs (regs_q),
      .sb   (sb_q),
      .wen  (bus.wen),
      .rd   (bus.rd),
      .din  (bus.din),
      .addr (bus.rs_addr[i*AW +: AW]),
      .data (rp_data[i]),
      .busy (rp_busy[i])
    );
  end

  assign bus.rs_data   = rp_data;
  assign bus.rs_busy   = rp_busy;
  assign bus.dbg_ack   = (state_q == ACK);
  assign bus.dbg_rdata = dbg_rdata_q;

  // dbg_acc kept as a single acceptance strobe for readability of the FSM.
  logic unused_acc;
  assign unused_acc = dbg_acc;

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Directed bench for rv32i_regfile_mp: bypass and non-bypass instances share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32i_regfile_mp;
  import rv32i_regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rv32i_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) b0 ();
  rv32i_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) b1 ();

  // The BYPASS=0 instance sees exactly the same inputs.
  assign b1.wen       = b0.wen;
  assign b1.rd        = b0.rd;
  assign b1.din       = b0.din;
  assign b1.rs_addr   = b0.rs_addr;
  assign b1.sb_set    = b0.sb_set;
  assign b1.sb_rd     = b0.sb_rd;
  assign b1.dbg_req   = b0.dbg_req;
  assign b1.dbg_we    = b0.dbg_we;
  assign b1.dbg_addr  = b0.dbg_addr;
  assign b1.dbg_wdata = b0.dbg_wdata;

  rv32i_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  rv32i_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_dut_nobyp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s no expected value queued, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] port(input logic [NRD*XLEN-1:0] v, input int i);
    return v[i*XLEN +: XLEN];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    b0.rs_addr = {a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.wen = 1'b0; b0.rd = '0; b0.din = '0; b0.rs_addr = '0;
    b0.sb_set = 1'b0; b0.sb_rd = '0;
    b0.dbg_req = 1'b0; b0.dbg_we = 1'b0; b0.dbg_addr = '0; b0.dbg_wdata = '0;
    rst_n = 1'b0;

    // Reset state
    #2;
    push(32'h0); chk("rst_rs_data0", port(b0.rs_data, 0));
    push(32'h0); chk("rst_rs_busy", {30'b0, b0.rs_busy});
    push(32'h0); chk("rst_dbg_ack", {31'b0, b0.dbg_ack});
    push(32'h0); chk("rst_dbg_rdata", b0.dbg_rdata);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Same-cycle write/read of x5: forwarded only with bypass
    b0.wen = 1'b1; b0.rd = 5'd5; b0.din = 32'hDEADBEEF; set_rs(5'd5, 5'd0);
    push(32'hDEADBEEF); push(32'h0);
    #1;
    chk("byp_same_cycle", port(b0.rs_data, 0));
    chk("nobyp_same_cycle", port(b1.rs_data, 0));
    step();
    b0.wen = 1'b0;
    push(32'hDEADBEEF); push(32'hDEADBEEF);
    #1;
    chk("byp_next_cycle", port(b0.rs_data, 0));
    chk("nobyp_next_cycle", port(b1.rs_data, 0));

    // Write to x0 is dropped and never forwarded
    step();
    b0.wen = 1'b1; b0.rd = 5'd0; b0.din = 32'hFFFFFFFF; set_rs(5'd0, 5'd0);
    push(32'h0); push(32'h0);
    #1;
    chk("x0_wr_p0", port(b0.rs_data, 0));
    chk("x0_wr_p1", port(b0.rs_data, 1));
    step();
    b0.wen = 1'b0;
    push(32'h0); push(32'h0);
    #1;
    chk("x0_after_p0", port(b0.rs_data, 0));
    chk("x0_after_p1", port(b0.rs_data, 1));

    // Scoreboard set on x7, then cleared by the resolving write
    step();
    b0.sb_set = 1'b1; b0.sb_rd = 5'd7;
    step();
    b0.sb_set = 1'b0; set_rs(5'd0, 5'd7);
    push(32'h1);
    #1;
    chk("sb_busy_x7", {31'b0, b0.rs_busy[1]});
    step();
    b0.wen = 1'b1; b0.rd = 5'd7; b0.din = 32'h77;
    push(32'h0); push(32'h1);
    #1;
    chk("sb_busy_byp_mask", {31'b0, b0.rs_busy[1]});
    chk("sb_busy_nobyp", {31'b0, b1.rs_busy[1]});
    step();
    b0.wen = 1'b0;
    push(32'h0); push(32'h77);
    #1;
    chk("sb_busy_cleared", {31'b0, b0.rs_busy[1]});
    chk("x7_data", port(b0.rs_data, 1));

    // Set and write on x9 in the same cycle: set wins
    step();
    b0.sb_set = 1'b1; b0.sb_rd = 5'd9; b0.wen = 1'b1; b0.rd = 5'd9; b0.din = 32'h99;
    step();
    b0.sb_set = 1'b0; b0.wen = 1'b0; set_rs(5'd0, 5'd9);
    push(32'h1); push(32'h99);
    #1;
    chk("sb_set_wins_x9", {31'b0, b0.rs_busy[1]});
    chk("x9_data", port(b0.rs_data, 1));

    // Scoreboard set on x0 is ignored
    step();
    b0.sb_set = 1'b1; b0.sb_rd = 5'd0;
    step();
    b0.sb_set = 1'b0; set_rs(5'd0, 5'd0);
    push(32'h0);
    #1;
    chk("sb_x0_ignored", {31'b0, b0.rs_busy[0]});

    // Debug write of x3 blocked for three cycles of core writes
    step();
    b0.dbg_req = 1'b1; b0.dbg_we = 1'b1; b0.dbg_addr = 5'd3; b0.dbg_wdata = 32'h1234;
    b0.wen = 1'b1; b0.rd = 5'd10; b0.din = 32'hA;
    for (int c = 0; c < 3; c++) begin
      step();
      push(32'h0);
      chk("dbgw_blocked", {31'b0, b0.dbg_ack});
    end
    b0.wen = 1'b0;
    step();
    push(32'h1);
    chk("dbgw_ack", {31'b0, b0.dbg_ack});
    b0.dbg_req = 1'b0;
    set_rs(5'd3, 5'd10);
    push(32'h1234); push(32'hA); push(32'h0);
    #1;
    chk("dbgw_x3", port(b0.rs_data, 0));
    chk("core_x10", port(b0.rs_data, 1));
    chk("dbgw_rdata_kept", b0.dbg_rdata);
    step();
    push(32'h0);
    chk("dbgw_ack_single", {31'b0, b0.dbg_ack});

    // Debug reads with dbg_req held: acks two cycles apart
    b0.dbg_req = 1'b1; b0.dbg_we = 1'b0; b0.dbg_addr = 5'd3;
    step();
    push(32'h1); chk("dbgr_ack1", {31'b0, b0.dbg_ack});
    push(32'h1234); chk("dbgr_rdata_x3", b0.dbg_rdata);
    b0.dbg_addr = 5'd5;
    step();
    push(32'h0); chk("dbgr_gap", {31'b0, b0.dbg_ack});
    push(32'h1234); chk("dbgr_rdata_hold", b0.dbg_rdata);
    step();
    push(32'h1); chk("dbgr_ack2", {31'b0, b0.dbg_ack});
    push(32'hDEADBEEF); chk("dbgr_rdata_x5", b0.dbg_rdata);
    step();
    step();
    push(32'h1); chk("dbgr_ack3", {31'b0, b0.dbg_ack});

    // Reset pulled while in ACK
    set_rs(5'd5, 5'd9);
    rst_n = 1'b0;
    #1;
    push(32'h0); chk("rst_mid_ack", {31'b0, b0.dbg_ack});
    push(32'h0); chk("rst_mid_x5", port(b0.rs_data, 0));
    push(32'h0); chk("rst_mid_sb9", {31'b0, b0.rs_busy[1]});
    push(32'h0); chk("rst_mid_rdata", b0.dbg_rdata);
    b0.dbg_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    push(32'h0); chk("post_rst_ack", {31'b0, b0.dbg_ack});
    push(32'h0); chk("post_rst_x5", port(b0.rs_data, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
